// File: rtl/cr_result_writeback_pkg.sv
// Purpose : shared types for the CR result writeback path (CR field/address types, field placement helper).
// Latency : n/a (types and a pure function only).
// Backpressure: n/a.
// Field numbering is MSB-first: CR0 is the most significant nibble of the 32-bit CR,
// and inside a field the MSB is LT, then GT, EQ, SO.
package cr_result_writeback_pkg;

    localparam int CR_FIELDS = 8;

    // One CR field: [3]=LT [2]=GT [1]=EQ [0]=SO (MSB-first architectural order).
    typedef logic [3:0] cr_field_t;
    // CR field address, 0..7 (0 = CR0 = most significant nibble).
    typedef logic [2:0] cr_addr_t;

    // Least-significant bit position of field f inside the 32-bit CR vector.
    function automatic int cr_field_lsb(input int f);
        return (CR_FIELDS - 1 - f) * 4;
    endfunction

endpackage

// File: rtl/cr_result_fifo.sv
// Purpose : generic ready-valid FIFO holding compare results (storage, pointers, count, full/empty).
// Latency : written entry visible at head one cycle after the push edge; no fall-through.
// Backpressure: pushes ignored when full, pops ignored when empty; same-cycle push+pop keeps count.
// Ports: clk/rst (async active-low), push_i/push_dat_i, pop_i, head_dat_o, full_o, empty_o, count_o.
module cr_result_fifo #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_dat_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_dat_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_en, pop_en;

    assign full_o     = (count_q == CNT_MAX);
    assign empty_o    = (count_q == '0);
    assign count_o    = count_q;
    assign head_dat_o = mem_q[rd_ptr_q];

    assign push_en = push_i && !full_o;
    assign pop_en  = pop_i && !empty_o;

    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_en) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop_en) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        if (push_en && !pop_en) begin
            count_d = count_q + CNT_ONE;
        end else if (pop_en && !push_en) begin
            count_d = count_q - CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: an entry is only observed once the count covers it.
    always_ff @(posedge clk) begin
        if (push_en) begin
            mem_q[wr_ptr_q] <= push_dat_i;
        end
    end

endmodule

// File: rtl/cr_result_writeback.sv
// Purpose : buffers compare results, broadcasts each once on the CR result bus, commits it to the CR.
// Latency : accept at edge N, broadcast from cycle N+1 (same cycle when CR_RESULT_BYPASS_EN and empty).
// Backpressure: input_ready = !full (no pass-through on same-cycle pop); broadcast held until bcast_grant.
// Ports: clk/rst (async active-low); input_valid/input_ready with rs_id_in, result_reg_addr_in, result_in;
//        bcast_valid/bcast_grant with bcast_rs_id, bcast_value; cr_wr_en/cr_wr_mask/cr_wr_value (mtcrf);
//        cr_out (CR0 = MSB nibble; cr_wr_mask MSB selects CR0); fifo_count.
// Optional: define CR_RESULT_BYPASS_EN to let an input skip the empty FIFO when the bus is granted.
module cr_result_writeback
    import cr_result_writeback_pkg::*;
#(
    parameter int RS_ID_WIDTH = 5,
    parameter int FIFO_DEPTH  = 4,
    localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   input_valid,
    output logic                   input_ready,
    input  logic [RS_ID_WIDTH-1:0] rs_id_in,
    input  cr_addr_t               result_reg_addr_in,
    input  cr_field_t              result_in,
    output logic                   bcast_valid,
    input  logic                   bcast_grant,
    output logic [RS_ID_WIDTH-1:0] bcast_rs_id,
    output cr_field_t              bcast_value,
    input  logic                   cr_wr_en,
    input  logic [7:0]             cr_wr_mask,
    input  logic [31:0]            cr_wr_value,
    output logic [31:0]            cr_out,
    output logic [CNT_W-1:0]       fifo_count
);

    localparam int ENT_W = RS_ID_WIDTH + $bits(cr_addr_t) + $bits(cr_field_t);

    logic [ENT_W-1:0]       push_dat, head_dat;
    logic                   fifo_push, fifo_pop;
    logic                   fifo_full, fifo_empty;
    logic [RS_ID_WIDTH-1:0] head_rs_id;
    cr_addr_t               head_addr;
    cr_field_t              head_value;
    cr_addr_t               bcast_addr;
    logic                   commit_vld;
    logic [31:0]            cr_q, cr_d;

    assign push_dat = {rs_id_in, result_reg_addr_in, result_in};
    assign {head_rs_id, head_addr, head_value} = head_dat;

    assign input_ready = !fifo_full;
    assign commit_vld  = bcast_valid && bcast_grant;
    assign fifo_pop    = commit_vld && !fifo_empty;

`ifdef CR_RESULT_BYPASS_EN
    logic byp_sel;
    assign byp_sel = fifo_empty;

    // Empty FIFO: the live input drives the bus; a granted input commits without being stored.
    always_comb begin
        bcast_valid = 1'b1;
        bcast_rs_id = head_rs_id;
        bcast_addr  = head_addr;
        bcast_value = head_value;
        if (byp_sel) begin
            bcast_valid = input_valid;
            bcast_rs_id = input_valid ? rs_id_in           : '0;
            bcast_addr  = input_valid ? result_reg_addr_in : '0;
            bcast_value = input_valid ? result_in          : '0;
        end
    end

    assign fifo_push = input_valid && input_ready && !(byp_sel && bcast_grant);
`else
    // Outputs depend only on FIFO state; stale storage is masked while empty.
    assign bcast_valid = !fifo_empty;
    assign bcast_rs_id = fifo_empty ? '0 : head_rs_id;
    assign bcast_addr  = fifo_empty ? '0 : head_addr;
    assign bcast_value = fifo_empty ? '0 : head_value;
    assign fifo_push   = input_valid && input_ready;
`endif

    cr_result_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_i     (fifo_push),
        .push_dat_i (push_dat),
        .pop_i      (fifo_pop),
        .head_dat_o (head_dat),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .count_o    (fifo_count)
    );

    // External masked write first, then the broadcast commit, so the commit wins on a shared field.
    always_comb begin
        cr_d = cr_q;
        for (int f = 0; f < CR_FIELDS; f++) begin
            if (cr_wr_en && cr_wr_mask[CR_FIELDS-1-f]) begin
                cr_d[cr_field_lsb(f) +: 4] = cr_wr_value[cr_field_lsb(f) +: 4];
            end
            if (commit_vld && (bcast_addr == cr_addr_t'(f))) begin
                cr_d[cr_field_lsb(f) +: 4] = bcast_value;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cr_q <= '0;
        end else begin
            cr_q <= cr_d;
        end
    end

    assign cr_out = cr_q;

endmodule

// File: tb/tb_cr_result_writeback.sv
// Purpose : self-checking bench for cr_result_writeback against a queue-based reference model.
// Latency : inputs change just after the rising edge, outputs compared at the falling edge and after the edge.
// Backpressure: model tracks occupancy, so refused pushes and held broadcasts are predicted.
module tb_cr_result_writeback;

    localparam int RSW   = 5;
    localparam int DEPTH = 4;

    logic        clk;
    logic        rst;
    logic        input_valid;
    logic        input_ready;
    logic [4:0]  rs_id_in;
    logic [2:0]  result_reg_addr_in;
    logic [3:0]  result_in;
    logic        bcast_valid;
    logic        bcast_grant;
    logic [4:0]  bcast_rs_id;
    logic [3:0]  bcast_value;
    logic        cr_wr_en;
    logic [7:0]  cr_wr_mask;
    logic [31:0] cr_wr_value;
    logic [31:0] cr_out;
    logic [2:0]  fifo_count;

    cr_result_writeback #(
        .RS_ID_WIDTH (RSW),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .input_valid        (input_valid),
        .input_ready        (input_ready),
        .rs_id_in           (rs_id_in),
        .result_reg_addr_in (result_reg_addr_in),
        .result_in          (result_in),
        .bcast_valid        (bcast_valid),
        .bcast_grant        (bcast_grant),
        .bcast_rs_id        (bcast_rs_id),
        .bcast_value        (bcast_value),
        .cr_wr_en           (cr_wr_en),
        .cr_wr_mask         (cr_wr_mask),
        .cr_wr_value        (cr_wr_value),
        .cr_out             (cr_out),
        .fifo_count         (fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int id;
        int addr;
        int val;
    } ent_t;

    ent_t q[$];
    int   fld[8];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // CR0 is the most significant nibble: shift fields in from CR0 to CR7.
    function automatic logic [31:0] cr_model();
        logic [31:0] r = 32'h0;
        for (int f = 0; f < 8; f++) r = (r << 4) | 32'(fld[f] & 15);
        return r;
    endfunction

    task automatic model_reset();
        q.delete();
        for (int f = 0; f < 8; f++) fld[f] = 0;
    endtask

    task automatic drive(input bit v, input int id, input int a, input int val, input bit g);
        input_valid        = v;
        rs_id_in           = 5'(id);
        result_reg_addr_in = 3'(a);
        result_in          = 4'(val);
        bcast_grant        = g;
    endtask

    // One clock: compare combinational outputs, let the edge happen, compare state.
    task automatic step(input string tag);
        bit   exp_rdy, exp_vld, acc, popped, byp;
        int   exp_id, exp_val;
        ent_t e;
        @(negedge clk);
        exp_rdy = (q.size() < DEPTH);
        byp     = 1'b0;
        exp_vld = 1'b0;
        exp_id  = 0;
        exp_val = 0;
        if (q.size() != 0) begin
            exp_vld = 1'b1;
            exp_id  = q[0].id;
            exp_val = q[0].val;
        end else begin
`ifdef CR_RESULT_BYPASS_EN
            if (input_valid) begin
                exp_vld = 1'b1;
                exp_id  = int'(rs_id_in);
                exp_val = int'(result_in);
                byp     = 1'b1;
            end
`endif
        end
        chk({tag, ".ready"}, 32'(input_ready), 32'(exp_rdy));
        chk({tag, ".bvld"},  32'(bcast_valid), 32'(exp_vld));
        chk({tag, ".bid"},   32'(bcast_rs_id), 32'(exp_id));
        chk({tag, ".bval"},  32'(bcast_value), 32'(exp_val));
        acc    = input_valid && exp_rdy;
        popped = exp_vld && bcast_grant;
        if (cr_wr_en) begin
            for (int f = 0; f < 8; f++)
                if (((cr_wr_mask >> (7 - f)) & 8'h1) != 0) fld[f] = int'((cr_wr_value >> (28 - 4 * f)) & 32'hF);
        end
        if (popped) begin
            if (byp) begin
                fld[result_reg_addr_in] = int'(result_in);
            end else begin
                e = q.pop_front();
                fld[e.addr] = e.val;
            end
        end
        if (acc && !(byp && popped)) begin
            e.id   = int'(rs_id_in);
            e.addr = int'(result_reg_addr_in);
            e.val  = int'(result_in);
            q.push_back(e);
        end
        @(posedge clk);
        #1;
        chk({tag, ".cr"},  cr_out, cr_model());
        chk({tag, ".cnt"}, 32'(fifo_count), 32'(q.size()));
    endtask

    initial begin
        rst         = 1'b0;
        cr_wr_en    = 1'b0;
        cr_wr_mask  = 8'h0;
        cr_wr_value = 32'h0;
        drive(0, 0, 0, 0, 0);
        model_reset();

        // Reset values while reset is held.
        #12;
        chk("rst.ready", 32'(input_ready), 32'd1);
        chk("rst.bvld",  32'(bcast_valid), 32'd0);
        chk("rst.bid",   32'(bcast_rs_id), 32'd0);
        chk("rst.bval",  32'(bcast_value), 32'd0);
        chk("rst.cr",    cr_out, 32'h0);
        chk("rst.cnt",   32'(fifo_count), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Single result to CR2 with grant held high.
        drive(1, 3, 2, 4'b0100, 1);
        step("single.push");
        drive(0, 0, 0, 0, 1);
        step("single.bcast");
        chk("single.cr_const", cr_out, 32'h0040_0000);

        // Fill without grant, fifth push refused, then drain in order.
        for (int i = 0; i < 5; i++) begin
            drive(1, 10 + i, i, 4'hF, 0);
            step("fill");
        end
        chk("fill.cnt4",  32'(fifo_count), 32'd4);
        chk("fill.rdy0",  32'(input_ready), 32'd0);
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 0, 0, 1);
            step("drain");
        end
        chk("drain.cr_hi", 32'(cr_out[31:16]), 32'hFFFF);
        chk("drain.rdy1",  32'(input_ready), 32'd1);

        // Pop to CR1 coinciding with an external write to CR1 and CR7.
        drive(1, 9, 1, 4'hA, 0);
        step("wr.push");
        drive(0, 0, 0, 0, 1);
        cr_wr_en    = 1'b1;
        cr_wr_mask  = 8'b0100_0001;
        cr_wr_value = 32'hFFFF_FFFF;
        step("wr.collide");
        cr_wr_en = 1'b0;
        chk("wr.cr1", 32'(cr_out[27:24]), 32'hA);
        chk("wr.cr7", 32'(cr_out[3:0]),   32'hF);

        // Asynchronous reset with three entries buffered.
        for (int i = 0; i < 3; i++) begin
            drive(1, 20 + i, 4 + i, 3 + i, 0);
            step("pre_rst");
        end
        drive(0, 0, 0, 0, 0);
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        chk("arst.bvld", 32'(bcast_valid), 32'd0);
        chk("arst.cnt",  32'(fifo_count), 32'd0);
        chk("arst.cr",   cr_out, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

`ifdef CR_RESULT_BYPASS_EN
        // Bypass: empty FIFO, granted input commits in the same cycle.
        drive(1, 7, 0, 4'b0010, 1);
        step("byp");
        chk("byp.cr0", 32'(cr_out[31:28]), 32'h2);
`endif

        // Streaming push+grant every cycle across pointer wrap.
        for (int i = 0; i < 20; i++) begin
            drive(1, int'($urandom_range(0, 31)), int'($urandom_range(0, 7)), int'($urandom_range(0, 15)), 1);
            step("stream");
`ifdef CR_RESULT_BYPASS_EN
            chk("stream.cnt0", 32'(fifo_count), 32'd0);
`else
            chk("stream.cnt1", 32'(fifo_count <= 3'd1), 32'd1);
`endif
        end

        // Random mix of pushes, grants and external writes.
        for (int i = 0; i < 300; i++) begin
            drive(($urandom_range(0, 2) != 0), int'($urandom_range(0, 31)), int'($urandom_range(0, 7)),
                  int'($urandom_range(0, 15)), ($urandom_range(0, 1) != 0));
            cr_wr_en    = ($urandom_range(0, 3) == 0);
            cr_wr_mask  = 8'($urandom());
            cr_wr_value = $urandom();
            step("rand");
        end
        cr_wr_en = 1'b0;
        for (int i = 0; i < 6; i++) begin
            drive(0, 0, 0, 0, 1);
            step("final_drain");
        end
        chk("final.empty", 32'(bcast_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
